exec_ctrl_pipe: RTL and testbench
=================================

EXEC_CTRL_PIPE -- requirements
Module: exec_ctrl_pipe

Interface
REQ-001 Parameters SHALL be: CTRL_W, default 3, width of execute_ctr (min 3); DEPTH, default 1, number of registered pipeline stages (1..4); MUL_LAT, default 4, extra execute cycles for a multiply (>=1).
REQ-002 Ports SHALL be as follows; there is one clock, and reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted when in_valid & in_ready.
- op  in  6  opcode.
- func  in  6  R-type function field.
- mux_select  in  1  1 = decode as R-type (func), 0 = decode as I-type (op).
- out_valid  out  1  execute_ctr valid.
- out_ready  in  1  consumer accepts.
- execute_ctr  out  CTRL_W  execute control code.
- illegal  out  1  unrecognised encoding, qualified by out_valid.
- busy  out  1  multiply wait in progress.

Function
REQ-003 Decode SHALL map R-type func values to codes: 100000 ADD->0; 100010 SUB->1; 100100 AND->2; 100101 OR->2; 000100 SLL->3; 001110 MULT->4.
REQ-004 Decode SHALL map I-type op values to codes: 001000 ADDI->0; 001010 SUBI->1; 001100 ANDI->2; 010100 SLLI->3.
REQ-005 Any other encoding SHALL yield code 0 with illegal=1; codes SHALL be zero-extended to CTRL_W.
REQ-006 Decode SHALL occur at acceptance; each stage SHALL hold {valid, code, illegal}.
REQ-007 A stage SHALL advance when it is empty or the next stage advances; the final stage SHALL advance on out_valid & out_ready.
REQ-008 in_ready SHALL be ~flush & (stage0 empty | stage0 advancing), combinationally, allowing full throughput of one instruction per cycle.
REQ-009 A non-MUL instruction SHALL appear at out_valid exactly DEPTH cycles after acceptance when there is no backpressure.
REQ-010 The FSM SHALL have states IDLE and MUL_WAIT.
- IDLE->MUL_WAIT when a code-4 entry lands in the final stage; the counter loads MUL_LAT-1.
- In MUL_WAIT: out_valid=0 and busy=1; the counter decrements each cycle; at 0 the FSM goes to IDLE and out_valid rises the next cycle.
- MUL latency SHALL be DEPTH+MUL_LAT cycles.
REQ-011 While the final stage is held (MUL_WAIT or out_ready=0), upstream stages SHALL stall without loss or duplication.
REQ-012 With out_valid=1 and out_ready=0, execute_ctr and illegal SHALL remain stable until accepted.
REQ-013 flush SHALL clear all stage valids, force the FSM to IDLE and zero the counter on the next edge. An instruction presented in the flush cycle SHALL be dropped (in_ready=0). flush has priority over every handshake in the same cycle.
REQ-014 Back-to-back MULs SHALL each incur the full MUL_LAT wait.

Reset
REQ-015 On a reset edge:
- all stage valids = 0;
- FSM = IDLE, counter = 0;
- out_valid = 0, execute_ctr = 0, illegal = 0, busy = 0;
- in_ready = 1 in the first cycle after reset.
REQ-016 Reset mid-MUL_WAIT or with a full pipeline SHALL discard all in-flight instructions; reset has priority over flush.

Structure
REQ-017 Opcode/func constants, control-code constants (CODE_ADD..CODE_MUL) and FSM state encodings SHALL live in shared package exec_ctrl_pkg.
REQ-018 Combinational decoding SHALL be a single sub-module, exec_ctrl_decode (op, func, mux_select -> code, illegal), instantiated once at the input.

Verification
REQ-019 Reset then in_valid with mux_select=1, func=100010, out_ready=1 -> out_valid after DEPTH cycles with execute_ctr=1, illegal=0.
REQ-020 Continuous stream: ADDI, ANDI, SLLI (mux_select=0), out_ready=1 -> codes 0, 2, 3 on consecutive cycles; in_ready stays 1.
REQ-021 MULT (func=001110) with MUL_LAT=4, DEPTH=1 -> busy=1 for 4 cycles; out_valid with code 4 at cycle 5; a following ADD stalls and emerges on the next cycle.
REQ-022 out_ready=0 for 3 cycles with the pipeline full -> in_ready=0, outputs stable; after release the instructions drain in order, none lost.
REQ-023 flush asserted during MUL_WAIT, with a new instruction also presented -> next cycle: out_valid=0, busy=0, input dropped; a following ADD decodes normally.
REQ-024 op=111111, mux_select=0 -> execute_ctr=0, illegal=1; reset asserted mid-pipeline -> all outputs 0 next cycle.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: shared opcode/func encodings, control codes and FSM states
package exec_ctrl_pkg;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLL  = 6'b000100;
  localparam logic [5:0] FN_MULT = 6'b001110;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_SLLI = 6'b010100;
  localparam logic [2:0] CODE_ADD = 3'd0;
  localparam logic [2:0] CODE_SUB = 3'd1;
  localparam logic [2:0] CODE_AND = 3'd2;
  localparam logic [2:0] CODE_SLL = 3'd3;
  localparam logic [2:0] CODE_MUL = 3'd4;
  typedef enum logic {IDLE = 1'b0, MUL_WAIT = 1'b1} state_t;
endpackage

// File: rtl/exec_ctrl_decode.sv
// exec_ctrl_decode: maps R-type func or I-type op to an execute control code
module exec_ctrl_decode
  import exec_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       mux_select,
  output logic [2:0] code,
  output logic       illegal
);
  always_comb begin
    code = CODE_ADD;
    illegal = 1'b0;
    if (mux_select)
      case (func)
        FN_ADD:        code = CODE_ADD;
        FN_SUB:        code = CODE_SUB;
        FN_AND, FN_OR: code = CODE_AND;
        FN_SLL:        code = CODE_SLL;
        FN_MULT:       code = CODE_MUL;
        default:       illegal = 1'b1;
      endcase
    else
      case (op)
        OP_ADDI: code = CODE_ADD;
        OP_SUBI: code = CODE_SUB;
        OP_ANDI: code = CODE_AND;
        OP_SLLI: code = CODE_SLL;
        default: illegal = 1'b1;
      endcase
  end
endmodule

// File: rtl/exec_ctrl_pipe.sv
// exec_ctrl_pipe: decode-at-accept control pipeline with a multiply wait state
module exec_ctrl_pipe
  import exec_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 3,
  parameter int DEPTH   = 1,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic              mux_select,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] execute_ctr,
  output logic              illegal,
  output logic              busy
);
  localparam int CW = $clog2(MUL_LAT + 1);
  logic [2:0] dec_code;
  logic dec_illegal, fire, load_mul;
  logic [DEPTH-1:0] v, il, adv, up_v, up_il;
  logic [CTRL_W-1:0] c [DEPTH];
  logic [CTRL_W-1:0] up_c [DEPTH];
  logic [CW-1:0] cnt, cnt_n;
  state_t state, state_n;
  exec_ctrl_decode u_dec (
    .op(op),
    .func(func),
    .mux_select(mux_select),
    .code(dec_code),
    .illegal(dec_illegal)
  );
  assign out_valid = v[DEPTH-1] & (state == IDLE);
  assign fire = out_valid & out_ready;
  assign busy = state == MUL_WAIT;
  assign in_ready = ~flush & adv[0];
  assign execute_ctr = c[DEPTH-1];
  assign illegal = il[DEPTH-1];
  assign load_mul = ~flush & adv[DEPTH-1] & up_v[DEPTH-1] & (up_c[DEPTH-1] == CTRL_W'(CODE_MUL));
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) adv[i] = fire | (|(~v >> i));
  end
  always_comb begin
    up_v = '0;
    up_il = '0;
    up_v[0] = in_valid & in_ready;
    up_il[0] = dec_illegal;
    up_c[0] = CTRL_W'(dec_code);
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_il[i] = il[i-1];
      up_c[i] = c[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      il <= '0;
      for (int i = 0; i < DEPTH; i++) c[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (flush) v[i] <= 1'b0;
        else if (adv[i]) begin
          v[i] <= up_v[i];
          il[i] <= up_il[i];
          c[i] <= up_c[i];
        end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = flush ? IDLE : (state == IDLE) ? (load_mul ? MUL_WAIT : IDLE) : (cnt == '0) ? IDLE : MUL_WAIT;
    cnt_n = flush ? '0 : (state == IDLE) ? (load_mul ? CW'(MUL_LAT - 1) : cnt) : (cnt == '0) ? cnt : cnt - 1'b1;
  end
endmodule

// File: tb/tb_exec_ctrl_pipe.sv
// tb_exec_ctrl_pipe: directed scenarios plus randomized run against a transaction-level model
module tb_exec_ctrl_pipe;
  localparam int CTRL_W = 3;
  localparam int DEPTH = 1;
  localparam int MUL_LAT = 4;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_MULT = 6'b001110;
  localparam logic [5:0] O_ADDI = 6'b001000, O_ANDI = 6'b001100, O_SLLI = 6'b010100;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, mux_select, out_valid, out_ready, illegal, busy;
  logic [5:0] op, func;
  logic [CTRL_W-1:0] execute_ctr;
  int tests = 0;
  int fails = 0;
  logic [5:0] flist [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000100, 6'b001110};
  logic [5:0] olist [4] = '{6'b001000, 6'b001010, 6'b001100, 6'b010100};
  logic [3:0] q [$];
  int age;
  logic exp_ov, exp_busy, exp_ir, prev_rst;

  always #5 clk = ~clk;

  exec_ctrl_pipe #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .func(func), .mux_select(mux_select), .out_valid(out_valid),
    .out_ready(out_ready), .execute_ctr(execute_ctr), .illegal(illegal), .busy(busy)
  );

  function automatic logic [3:0] ref_dec(input logic ms, input logic [5:0] o, input logic [5:0] f);
    if (ms)
      case (f)
        6'b100000: return 4'h0;
        6'b100010: return 4'h1;
        6'b100100, 6'b100101: return 4'h2;
        6'b000100: return 4'h3;
        6'b001110: return 4'h4;
        default: return 4'h8;
      endcase
    else
      case (o)
        6'b001000: return 4'h0;
        6'b001010: return 4'h1;
        6'b001100: return 4'h2;
        6'b010100: return 4'h3;
        default: return 4'h8;
      endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] code, input logic il);
    chk({tag, "_valid"}, out_valid, v);
    if (v) begin
      chk({tag, "_code"}, execute_ctr, code);
      chk({tag, "_illegal"}, illegal, il);
    end
  endtask

  task automatic set_in(input logic v, input logic ms, input logic [5:0] o, input logic [5:0] f,
                        input logic ordy, input logic fl);
    in_valid = v;
    mux_select = ms;
    op = o;
    func = f;
    out_ready = ordy;
    flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 6'h0, 6'h0, 1, 0);
    tick;
    tick;
    #1;
    chk_out("reset", 0, 0, 0);
    chk("reset_ctr", execute_ctr, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    // single SUB
    set_in(1, 1, 6'h0, F_SUB, 1, 0);
    #1 chk("sub_in_ready", in_ready, 1);
    tick;
    set_in(0, 1, 6'h0, F_SUB, 1, 0);
    #1 chk_out("sub", 1, 1, 0);
    tick;
    // streaming I-type
    set_in(1, 0, O_ADDI, 6'h0, 1, 0);
    #1 chk("stream_ir0", in_ready, 1);
    tick;
    set_in(1, 0, O_ANDI, 6'h0, 1, 0);
    #1 chk("stream_ir1", in_ready, 1);
    chk_out("stream0", 1, 0, 0);
    tick;
    set_in(1, 0, O_SLLI, 6'h0, 1, 0);
    #1 chk("stream_ir2", in_ready, 1);
    chk_out("stream1", 1, 2, 0);
    tick;
    set_in(0, 0, 6'h0, 6'h0, 1, 0);
    #1 chk_out("stream2", 1, 3, 0);
    tick;
    #1 chk_out("stream_end", 0, 0, 0);
    // multiply then stalled ADD
    set_in(1, 1, 6'h0, F_MULT, 1, 0);
    #1 chk("mul_ir", in_ready, 1);
    tick;
    set_in(1, 1, 6'h0, F_ADD, 1, 0);
    for (int i = 0; i < MUL_LAT; i++) begin
      #1;
      chk("mul_busy", busy, 1);
      chk("mul_ov", out_valid, 0);
      chk("mul_stall_ir", in_ready, 0);
      tick;
    end
    #1 chk("mul_done_busy", busy, 0);
    chk_out("mul", 1, 4, 0);
    chk("mul_done_ir", in_ready, 1);
    tick;
    set_in(0, 1, 6'h0, F_ADD, 1, 0);
    #1 chk_out("after_mul_add", 1, 0, 0);
    tick;
    // backpressure hold
    set_in(1, 1, 6'h0, F_SUB, 0, 0);
    #1 chk("bp_ir0", in_ready, 1);
    tick;
    set_in(1, 0, O_ANDI, 6'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ir", in_ready, 0);
      chk_out("bp_hold", 1, 1, 0);
      tick;
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ir", in_ready, 1);
    chk_out("bp_release", 1, 1, 0);
    tick;
    set_in(0, 0, 6'h0, 6'h0, 1, 0);
    #1 chk_out("bp_drain", 1, 2, 0);
    tick;
    #1 chk_out("bp_empty", 0, 0, 0);
    // flush during multiply wait
    set_in(1, 1, 6'h0, F_MULT, 1, 0);
    tick;
    set_in(0, 1, 6'h0, F_ADD, 1, 0);
    #1 chk("fl_busy_pre", busy, 1);
    tick;
    set_in(1, 1, 6'h0, F_ADD, 1, 1);
    #1 chk("fl_ir", in_ready, 0);
    tick;
    set_in(0, 1, 6'h0, F_ADD, 1, 0);
    #1 chk("fl_busy", busy, 0);
    chk_out("fl_ov", 0, 0, 0);
    tick;
    #1 chk_out("fl_dropped", 0, 0, 0);
    set_in(1, 1, 6'h0, F_ADD, 1, 0);
    #1 chk("fl_add_ir", in_ready, 1);
    tick;
    set_in(0, 1, 6'h0, F_ADD, 1, 0);
    #1 chk_out("fl_add", 1, 0, 0);
    tick;
    // illegal opcode
    set_in(1, 0, 6'h3f, 6'h0, 1, 0);
    tick;
    set_in(0, 0, 6'h0, 6'h0, 1, 0);
    #1 chk_out("illegal_op", 1, 0, 1);
    tick;
    // reset with a full pipeline
    set_in(1, 1, 6'h0, F_SUB, 0, 0);
    tick;
    set_in(1, 0, O_ADDI, 6'h0, 0, 0);
    #1 chk_out("rst_full_pre", 1, 1, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    set_in(0, 0, 6'h0, 6'h0, 1, 0);
    #1 chk_out("rst_full", 0, 0, 0);
    chk("rst_full_ctr", execute_ctr, 0);
    chk("rst_full_il", illegal, 0);
    chk("rst_full_busy", busy, 0);
    chk("rst_full_ir", in_ready, 1);
    tick;
    // reset during multiply wait
    set_in(1, 1, 6'h0, F_MULT, 1, 0);
    tick;
    set_in(0, 0, 6'h0, 6'h0, 1, 0);
    #1 chk("rst_mul_pre", busy, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      #1 chk("rst_mul_busy", busy, 0);
      chk_out("rst_mul", 0, 0, 0);
      tick;
    end
    // randomized run against the queue model
    age = 0;
    prev_rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset = (n == 0) || ($urandom_range(0, 199) == 0);
      flush = $urandom_range(0, 24) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      mux_select = 1'($urandom);
      func = ($urandom_range(0, 4) == 0) ? 6'($urandom) : flist[$urandom_range(0, 5)];
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : olist[$urandom_range(0, 3)];
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      exp_ov = q.size() > 0 && (q[0][2:0] != 3'd4 || age >= MUL_LAT);
      exp_busy = q.size() > 0 && q[0][2:0] == 3'd4 && age < MUL_LAT;
      exp_ir = !flush && (q.size() < DEPTH || (exp_ov && out_ready));
      if (!reset) begin
        chk("rnd_out_valid", out_valid, exp_ov);
        chk("rnd_busy", busy, exp_busy);
        chk("rnd_in_ready", in_ready, exp_ir);
        if (exp_ov) begin
          chk("rnd_code", execute_ctr, q[0][2:0]);
          chk("rnd_illegal", illegal, q[0][3]);
        end
        if (prev_rst) begin
          chk("rnd_rst_ctr", execute_ctr, 0);
          chk("rnd_rst_il", illegal, 0);
        end
      end
      prev_rst = reset;
      if (reset || flush) begin
        q.delete();
        age = 0;
      end else begin
        if (exp_ov && out_ready) begin
          void'(q.pop_front());
          age = 0;
        end else if (q.size() > 0) age++;
        if (in_valid && exp_ir) q.push_back(ref_dec(mux_select, op, func));
      end
      tick;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
